// File: rtl/mul_seq_if.sv
// mul_seq_if: operand/control/result bundle between the register-file stage and the iterative multiplier.
interface mul_seq_if #(parameter int W_DATA = 32);
  logic start, c_mul_signed, c_mul_hi, flush, busy, done;
  logic [W_DATA-1:0] rfa, rfb, result;
  modport master (output start, c_mul_signed, c_mul_hi, flush, rfa, rfb, input busy, done, result);
  modport slave (input start, c_mul_signed, c_mul_hi, flush, rfa, rfb, output busy, done, result);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: iterative shift-add 32x32 multiplier returning the low or high product half.
module mul_seq #(
  parameter int W_DATA = 32,
  parameter int N_ITER = 32
) (
  input logic clk,
  input logic rst,
  mul_seq_if.slave bus
);
  localparam int W_CNT = $clog2(N_ITER + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t r_state, w_next;
  logic [W_DATA-1:0] r_mcand, r_mplier, r_result, w_abs_a, w_abs_b;
  logic [2*W_DATA-1:0] r_acc, w_prod;
  logic [W_DATA:0] w_sum;
  logic [W_CNT-1:0] r_cnt;
  logic r_neg, r_hi, w_accept;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = bus.flush ? IDLE :
             (r_state == IDLE || r_state == DONE) ? (bus.start ? RUN : IDLE) :
             (r_state == RUN) ? ((r_cnt == W_CNT'(N_ITER - 1)) ? FIX : RUN) : DONE;
  always_comb begin
    bus.busy = (r_state == RUN) || (r_state == FIX);
    bus.done = (r_state == DONE);
  end
  assign w_accept = (w_next == RUN) && (r_state == IDLE || r_state == DONE);
  // -2^31 negates to itself, which is the correct unsigned magnitude
  assign w_abs_a = (bus.c_mul_signed && bus.rfa[W_DATA-1]) ? -bus.rfa : bus.rfa;
  assign w_abs_b = (bus.c_mul_signed && bus.rfb[W_DATA-1]) ? -bus.rfb : bus.rfb;
  assign w_sum = {1'b0, r_acc[2*W_DATA-1:W_DATA]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_prod = r_neg ? -r_acc : r_acc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_mcand <= '0;
      r_mplier <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_hi <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_mcand <= w_abs_a;
      r_mplier <= w_abs_b;
      r_neg <= bus.c_mul_signed & (bus.rfa[W_DATA-1] ^ bus.rfb[W_DATA-1]);
      r_hi <= bus.c_mul_hi;
      r_acc <= '0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_acc <= {w_sum, r_acc[W_DATA-1:1]};
      r_mplier <= r_mplier >> 1;
      r_cnt <= r_cnt + W_CNT'(1);
    end else if (r_state == FIX && !bus.flush)
      r_result <= r_hi ? w_prod[2*W_DATA-1:W_DATA] : w_prod[W_DATA-1:0];
  assign bus.result = r_result;
endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed vectors with a result scoreboard checked by an independent done monitor.
module tb_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] last_res;
  mul_seq_if #(.W_DATA(32)) bus ();
  mul_seq #(.W_DATA(32), .N_ITER(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk)
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h expected no done", bus.result);
      end else chk("result", bus.result, sb.pop_front());
    end
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic h,
                       input logic [31:0] exp, input bit push);
    bus.start = 1'b1;
    bus.rfa = a;
    bus.rfb = b;
    bus.c_mul_signed = s;
    bus.c_mul_hi = h;
    if (push) sb.push_back(exp);
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  task automatic wait_done(input int pre);
    int n = pre;
    while (bus.busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(n), 32'd33);
    chk("done_pulse", {31'd0, bus.done}, 32'd1);
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s, input logic h,
                    input logic [31:0] exp);
    issue(a, b, s, h, exp, 1'b1);
    wait_done(0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.c_mul_signed = 1'b0;
    bus.c_mul_hi = 1'b0;
    bus.rfa = '0;
    bus.rfb = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    op(32'h0000_1234, 32'h0000_0100, 1'b0, 1'b0, 32'h0012_3400);
    issue(32'd7, 32'd9, 1'b0, 1'b0, 32'd63, 1'b0);
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst_done", {31'd0, bus.done}, 32'd0);
    chk("midrst_result", bus.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b1, 32'hFFFF_FFFF);
    op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 32'hFFFF_FFFE);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFE);
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0001);
    op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFF1);
    op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h4000_0000, 1'b1);
    wait_done(0);
    issue(32'd3, 32'd5, 1'b0, 1'b0, 32'h0000_000F, 1'b1);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    wait_done(0);
    @(negedge clk);
    issue(32'h0000_1234, 32'h0000_0100, 1'b0, 1'b0, 32'h0012_3400, 1'b1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.rfa = 32'hDEAD_BEEF;
    bus.rfb = 32'h0000_0003;
    bus.c_mul_signed = 1'b1;
    bus.c_mul_hi = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(5);
    @(negedge clk);
    last_res = 32'h0012_3400;
    issue(32'd11, 32'd13, 1'b0, 1'b0, 32'd143, 1'b0);
    repeat (19) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_done", {31'd0, bus.done}, 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_result", bus.result, last_res);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Iterative 32x32 multiplier in the execute stage, directly downstream of the register file.
- Consumes the rfa/rfb operand pair and produces a 32-bit result (low or high half of the 64-bit product) for the writeback path.
- Its busy output stalls the pipeline while the multiply is in flight.

Parameters:
- W_DATA, 32, operand and result width; the product is 2*W_DATA bits.
- N_ITER, 32, shift-add iterations; must equal W_DATA.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a multiply; sampled on rising clk.
- c_mul_signed  input  1  1 = two's-complement operands, 0 = unsigned; latched at start.
- c_mul_hi  input  1  1 = return product[63:32], 0 = product[31:0]; latched at start.
- flush  input  1  abort any in-flight multiply.
- rfa  input  W_DATA  multiplicand from the register file; latched at start.
- rfb  input  W_DATA  multiplier from the register file; latched at start.
- busy  output  1  high while the unit is in RUN or FIX.
- done  output  1  one-cycle pulse; result is valid.
- result  output  W_DATA  selected product half; holds until the next done.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, busy=0, done=0, result=0, iteration counter=0, product accumulator=0.
  - Taking effect mid-operation discards the operation; no done is produced.
- States: IDLE, RUN, FIX, DONE. busy = (state==RUN || state==FIX). done = (state==DONE). Both are decoded from state, with no extra logic.
- IDLE:
  - start=1 at edge N → latch operand magnitudes (|rfa|, |rfb| when c_mul_signed, raw values otherwise), the negate flag (rfa[31]^rfb[31] when signed, else 0) and c_mul_hi.
  - Then clear the accumulator and counter, and go to RUN.
- RUN, one iteration per edge:
  - If multiplier bit 0 = 1, add the multiplicand to acc[63:32], keeping the carry into a 65th bit.
  - Shift {carry, acc} right by 1 and shift the multiplier right by 1; counter++.
  - After the 32nd iteration (edge N+32) go to FIX.
- FIX (edge N+33):
  - Form P = negate ? (~acc+1) : acc over 64 bits.
  - result <= c_mul_hi_latched ? P[63:32] : P[31:0]; go to DONE.
- DONE:
  - done=1 for exactly one cycle (between edges N+33 and N+34), busy=0.
  - At edge N+34: start=1 → accept a new operation exactly as from IDLE (back-to-back); otherwise → IDLE.
- Latency: start sampled at edge N; busy=1 from edge N to edge N+33; done pulse after edge N+33.
- start while busy=1: ignored; the latched operands are unaffected.
- rfa/rfb/control changes during RUN/FIX: ignored, since only the values latched at start are used.
- flush=1 in any state: next state=IDLE, no done pulse, result unchanged. flush takes priority over start on the same edge.
- Magnitude corner: signed -2^31 has magnitude 2^31, which is representable in the 32-bit unsigned register. The product magnitude ≤ 2^62 fits in 64 bits.
- result changes only in FIX. result holds its previous value through IDLE, RUN and DONE→IDLE.

Test Plan:
- Reset mid-run: start with rfa=7, rfb=9, assert rst at cycle 10 → busy=0, done=0 and result=0 immediately (asynchronously). No done follows.
- Basic unsigned low: rfa=0x0000_1234, rfb=0x0000_0100, signed=0, hi=0 → done after edge N+33, result=0x0012_3400. busy high for exactly 33 cycles.
- Signed high: rfa=0xFFFF_FFFF (-1), rfb=0x0000_0002, signed=1, hi=1 → result=0xFFFF_FFFF. Repeat with hi=0 → result=0xFFFF_FFFE.
- Unsigned high overflow: rfa=rfb=0xFFFF_FFFF, signed=0, hi=1 → result=0xFFFF_FFFE. With hi=0 → 0x0000_0001.
- Corner and back-to-back:
  - rfa=rfb=0x8000_0000, signed=1, hi=1 → result=0x4000_0000.
  - Assert start again in the DONE cycle with rfa=3, rfb=5, signed=0, hi=0 → busy rises immediately, and a second done follows 34 cycles later with result=0x0000_000F.
- Flush and ignored start:
  - Assert start at cycle 5 of RUN with different operands → ignored; the original result is produced.
  - Assert flush at RUN cycle 20 → IDLE next edge, no done, result holds its prior value.
